// File: rtl/cnn1d_pkg.sv
// Shared types and sizing helpers for the 1-D CNN layer blocks.
package cnn1d_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_t;

  typedef enum logic [2:0] {
    NS_IDLE  = 3'd0,
    NS_MAC   = 3'd1,
    NS_DRAIN = 3'd2,
    NS_FIN   = 3'd3,
    NS_OUT   = 3'd4
  } neuron_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Wide enough that summing NUM_INPUTS full-width products can never wrap.
  function automatic int acc_width(input int data_width, input int num_inputs);
    return 2 * data_width + clog2(num_inputs) + 1;
  endfunction

endpackage

// File: rtl/neuron_multi_if.sv
// Input-vector and result handshakes of a neuron; slave is the neuron side.
interface neuron_multi_if #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_INPUTS = 8
);
  logic                                  neuron_ready_in;
  logic                                  neuron_valid_in;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] neuron_data_in;
  logic [1:0]                            neuron_act_mode;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] neuron_weights;
  logic [DATA_WIDTH-1:0]                 neuron_bias;
  logic                                  neuron_ready_out;
  logic                                  neuron_valid_out;
  logic [DATA_WIDTH-1:0]                 neuron_data_out;
  logic                                  neuron_sat_out;

  modport slave (
    output neuron_ready_in,
    input  neuron_valid_in, neuron_data_in, neuron_act_mode,
    input  neuron_weights, neuron_bias, neuron_ready_out,
    output neuron_valid_out, neuron_data_out, neuron_sat_out
  );

  modport master (
    input  neuron_ready_in,
    output neuron_valid_in, neuron_data_in, neuron_act_mode,
    output neuron_weights, neuron_bias, neuron_ready_out,
    input  neuron_valid_out, neuron_data_out, neuron_sat_out
  );
endinterface

// File: rtl/neuron_activate.sv
// Combinational post-processing: bias add, fixed-point rescale, saturation
// and activation of a wide accumulator value.
module neuron_activate
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int FRACTION    = 9,
  parameter int ACC_W       = 28,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  input  logic [DATA_WIDTH-1:0]      bias_i,
  input  logic [1:0]                 act_mode_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       sat_o
);

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0]      bias_ext_s;
  logic signed [ACC_W:0]      sum_s;
  logic signed [ACC_W:0]      res_s;
  logic signed [DATA_WIDTH-1:0] clamp_s;
  logic signed [DATA_WIDTH-1:0] leaky_s;

  // Bias add, floor rescale, clamp; sat reflects the clamp only, never the activation.
  always_comb begin
    bias_ext_s = {{(ACC_W+1-DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i};
    sum_s      = {acc_i[ACC_W-1], acc_i} + (bias_ext_s <<< FRACTION);
    res_s      = sum_s >>> FRACTION;
    if (res_s > MAX_V) begin
      clamp_s = MAX_V[DATA_WIDTH-1:0];
      sat_o   = 1'b1;
    end else if (res_s < MIN_V) begin
      clamp_s = MIN_V[DATA_WIDTH-1:0];
      sat_o   = 1'b1;
    end else begin
      clamp_s = res_s[DATA_WIDTH-1:0];
      sat_o   = 1'b0;
    end
    leaky_s = clamp_s >>> LEAKY_SHIFT;
    case (act_mode_t'(act_mode_i))
      ACT_RELU:  data_o = clamp_s[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : clamp_s;
      ACT_LEAKY: data_o = clamp_s[DATA_WIDTH-1] ? leaky_s : clamp_s;
      default:   data_o = clamp_s;
    endcase
  end

endmodule

// File: rtl/neuron_multi.sv
// Multi-multiplier neuron: beat-serial dot product with NUM_MULTS products per
// beat, then bias/rescale/saturate/activate, with valid/ready on both sides.
module neuron_multi
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int FRACTION    = 9,
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_MULTS   = 2,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic           clk,
  input  logic           rst,
  neuron_multi_if.slave  nif
);

  localparam int BEATS  = NUM_INPUTS / NUM_MULTS;
  localparam int BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int IDX_W  = (NUM_INPUTS > 1) ? clog2(NUM_INPUTS) : 1;
  localparam int ACC_W  = acc_width(DATA_WIDTH, NUM_INPUTS);
  localparam int PW     = 2 * DATA_WIDTH;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [2:0] ST_IDLE  = NS_IDLE;
  localparam logic [2:0] ST_MAC   = NS_MAC;
  localparam logic [2:0] ST_DRAIN = NS_DRAIN;
  localparam logic [2:0] ST_FIN   = NS_FIN;
  localparam logic [2:0] ST_OUT   = NS_OUT;

  logic [2:0]                            state_q, state_d;
  logic [BEAT_W-1:0]                     beat_q, beat_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]                            mode_q, mode_d;
  logic signed [ACC_W-1:0]               p_q, p_d;
  logic                                  pv_q, pv_d;
  logic signed [ACC_W-1:0]               acc_q, acc_d;
  logic                                  vout_q, vout_d;
  logic [DATA_WIDTH-1:0]                 dout_q, dout_d;
  logic                                  sat_q, sat_d;

  logic [IDX_W-1:0]        idx_s;
  logic signed [PW-1:0]    xe_s, we_s, pr_s;
  logic signed [ACC_W-1:0] psum_s;
  logic [DATA_WIDTH-1:0]   act_data_s;
  logic                    act_sat_s;

  // Sum of the NUM_MULTS products selected by the current beat.
  always_comb begin
    psum_s = '0;
    idx_s  = '0;
    xe_s   = '0;
    we_s   = '0;
    pr_s   = '0;
    for (int m = 0; m < NUM_MULTS; m++) begin
      idx_s  = IDX_W'(int'(beat_q) * NUM_MULTS + m);
      xe_s   = {{DATA_WIDTH{data_q[idx_s][DATA_WIDTH-1]}}, data_q[idx_s]};
      we_s   = {{DATA_WIDTH{nif.neuron_weights[idx_s][DATA_WIDTH-1]}}, nif.neuron_weights[idx_s]};
      pr_s   = xe_s * we_s;
      psum_s = psum_s + {{(ACC_W-PW){pr_s[PW-1]}}, pr_s};
    end
  end

  neuron_activate #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACTION    (FRACTION),
    .ACC_W       (ACC_W),
    .LEAKY_SHIFT (LEAKY_SHIFT)
  ) u_activate (
    .acc_i      (acc_q),
    .bias_i     (nif.neuron_bias),
    .act_mode_i (mode_q),
    .data_o     (act_data_s),
    .sat_o      (act_sat_s)
  );

  // FSM and datapath next-state; products lag one beat, so DRAIN folds in the last one.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    mode_d  = mode_q;
    p_d     = p_q;
    pv_d    = pv_q;
    acc_d   = acc_q;
    vout_d  = vout_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (nif.neuron_valid_in) begin
          data_d  = nif.neuron_data_in;
          mode_d  = nif.neuron_act_mode;
          beat_d  = '0;
          acc_d   = '0;
          pv_d    = 1'b0;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        p_d  = psum_s;
        pv_d = 1'b1;
        if (pv_q) begin
          acc_d = acc_q + p_q;
        end else begin
          acc_d = acc_q;
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pv_q) begin
          acc_d = acc_q + p_q;
        end else begin
          acc_d = acc_q;
        end
        state_d = ST_FIN;
      end
      ST_FIN: begin
        dout_d  = act_data_s;
        sat_d   = act_sat_s;
        vout_d  = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (nif.neuron_ready_out) begin
          vout_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          vout_d  = 1'b1;
        end
      end
      default: begin
        vout_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      mode_q  <= 2'd0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign nif.neuron_ready_in  = (state_q == ST_IDLE);
  assign nif.neuron_valid_out = vout_q;
  assign nif.neuron_data_out  = dout_q;
  assign nif.neuron_sat_out   = sat_q;

endmodule

// File: tb/tb_neuron_multi.sv
// Directed and random checks of neuron_multi at NUM_INPUTS=4 with 1, 2 and 4 multipliers.
module tb_neuron_multi;
  import cnn1d_pkg::*;

  localparam int DW = 12;
  localparam int FR = 9;
  localparam int NI = 4;

  typedef logic [NI-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  neuron_multi_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus  ();
  neuron_multi_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus1 ();
  neuron_multi_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus4 ();

  neuron_multi #(.DATA_WIDTH(DW), .FRACTION(FR), .NUM_INPUTS(NI), .NUM_MULTS(2), .LEAKY_SHIFT(3))
    dut  (.clk(clk), .rst(rst), .nif(bus.slave));
  neuron_multi #(.DATA_WIDTH(DW), .FRACTION(FR), .NUM_INPUTS(NI), .NUM_MULTS(1), .LEAKY_SHIFT(3))
    dut1 (.clk(clk), .rst(rst), .nif(bus1.slave));
  neuron_multi #(.DATA_WIDTH(DW), .FRACTION(FR), .NUM_INPUTS(NI), .NUM_MULTS(4), .LEAKY_SHIFT(3))
    dut4 (.clk(clk), .rst(rst), .nif(bus4.slave));

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = DW'(a);
    v[1] = DW'(b);
    v[2] = DW'(c);
    v[3] = DW'(d);
    return v;
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void ref_model(input vec_t x, input vec_t w, input logic [DW-1:0] b,
                                    input logic [1:0] mode, output logic [DW-1:0] y, output logic s);
    longint acc, r;
    acc = 0;
    for (int i = 0; i < NI; i++) acc += longint'($signed(x[i])) * longint'($signed(w[i]));
    r = floor_div(acc + longint'($signed(b)) * 512, 512);
    s = 1'b0;
    if (r > 2047)  begin r = 2047;  s = 1'b1; end
    if (r < -2048) begin r = -2048; s = 1'b1; end
    if (r < 0 && mode == 2'd1) r = 0;
    if (r < 0 && mode == 2'd2) r = floor_div(r, 8);
    y = DW'(r);
  endfunction

  task automatic idle_inputs();
    bus.neuron_valid_in  = 1'b0; bus.neuron_data_in  = '0; bus.neuron_act_mode  = 2'd0;
    bus.neuron_weights   = '0;   bus.neuron_bias     = '0; bus.neuron_ready_out = 1'b0;
    bus1.neuron_valid_in = 1'b0; bus1.neuron_data_in = '0; bus1.neuron_act_mode = 2'd0;
    bus1.neuron_weights  = '0;   bus1.neuron_bias    = '0; bus1.neuron_ready_out = 1'b0;
    bus4.neuron_valid_in = 1'b0; bus4.neuron_data_in = '0; bus4.neuron_act_mode = 2'd0;
    bus4.neuron_weights  = '0;   bus4.neuron_bias    = '0; bus4.neuron_ready_out = 1'b0;
  endtask

  // Presents a vector on the main bus and returns #1 after the accepting edge.
  task automatic accept(input vec_t x, input vec_t w, input int bias, input logic [1:0] mode);
    bit ok;
    bus.neuron_data_in  = x;
    bus.neuron_weights  = w;
    bus.neuron_bias     = DW'(bias);
    bus.neuron_act_mode = mode;
    bus.neuron_valid_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.neuron_ready_in) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout: ready_in never rose"); end
    @(posedge clk); #1;
    bus.neuron_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.neuron_valid_out) begin edges = i; break; end
    end
  endtask

  task automatic consume();
    bus.neuron_ready_out = 1'b1;
    @(posedge clk); #1;
    bus.neuron_ready_out = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.neuron_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.neuron_valid_out); end
    checks++; if (bus.neuron_data_out !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", $signed(bus.neuron_data_out)); end
    checks++; if (bus.neuron_sat_out !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", bus.neuron_sat_out); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.neuron_ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in: got %b want 1", bus.neuron_ready_in); end
  endtask

  task automatic test_basic();
    int e;
    accept(mk(512, 512, 512, 512), mk(512, 256, 0, -512), 0, 2'd1);
    wait_valid(e);
    checks++; if (e != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", e); end
    checks++; if (bus.neuron_data_out !== 12'd256) begin errors++; $display("FAIL basic_data: got %0d want 256", $signed(bus.neuron_data_out)); end
    checks++; if (bus.neuron_sat_out !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", bus.neuron_sat_out); end
    consume();
    checks++; if (bus.neuron_valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.neuron_valid_out); end
    checks++; if (bus.neuron_ready_in !== 1'b1) begin errors++; $display("FAIL basic_ready_in: got %b want 1", bus.neuron_ready_in); end
  endtask

  task automatic test_modes();
    int e;
    int exp_v [3] = '{-2048, 0, -256};
    for (int m = 0; m < 3; m++) begin
      accept(mk(512, 512, 512, 512), mk(-512, -512, -512, -512), 0, 2'(m));
      wait_valid(e);
      checks++; if (e != 4) begin errors++; $display("FAIL mode%0d_latency: got %0d want 4", m, e); end
      checks++; if (bus.neuron_data_out !== DW'(exp_v[m])) begin errors++; $display("FAIL mode%0d_data: got %0d want %0d", m, $signed(bus.neuron_data_out), exp_v[m]); end
      checks++; if (bus.neuron_sat_out !== 1'b0) begin errors++; $display("FAIL mode%0d_sat: got %b want 0", m, bus.neuron_sat_out); end
      consume();
    end
  endtask

  task automatic test_saturation();
    int e;
    accept(mk(1024, 1024, 1024, 1024), mk(1024, 1024, 1024, 1024), 256, 2'd0);
    wait_valid(e);
    checks++; if (bus.neuron_data_out !== 12'd2047) begin errors++; $display("FAIL sat_pos_data: got %0d want 2047", $signed(bus.neuron_data_out)); end
    checks++; if (bus.neuron_sat_out !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b want 1", bus.neuron_sat_out); end
    consume();
    accept(mk(1024, 1024, 1024, 1024), mk(-1024, -1024, -1024, -1024), 256, 2'd0);
    wait_valid(e);
    checks++; if (bus.neuron_data_out !== 12'h800) begin errors++; $display("FAIL sat_neg_data: got %0d want -2048", $signed(bus.neuron_data_out)); end
    checks++; if (bus.neuron_sat_out !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b want 1", bus.neuron_sat_out); end
    consume();
  endtask

  task automatic test_backpressure();
    int e;
    accept(mk(512, 512, 512, 512), mk(512, 256, 0, -512), 0, 2'd1);
    wait_valid(e);
    bus.neuron_data_in  = mk(512, 512, 512, 512);
    bus.neuron_weights  = mk(-512, -512, -512, -512);
    bus.neuron_act_mode = 2'd0;
    bus.neuron_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.neuron_valid_out !== 1'b1 || bus.neuron_data_out !== 12'd256 || bus.neuron_sat_out !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%b want v=1 d=256 s=0", i, bus.neuron_valid_out, $signed(bus.neuron_data_out), bus.neuron_sat_out); end
      checks++; if (bus.neuron_ready_in !== 1'b0) begin errors++; $display("FAIL bp_ready_in[%0d]: got %b want 0", i, bus.neuron_ready_in); end
    end
    bus.neuron_ready_out = 1'b1;
    @(posedge clk); #1;
    bus.neuron_ready_out = 1'b0;
    checks++; if (bus.neuron_valid_out !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", bus.neuron_valid_out); end
    checks++; if (bus.neuron_ready_in !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", bus.neuron_ready_in); end
    @(posedge clk); #1;
    bus.neuron_valid_in = 1'b0;
    wait_valid(e);
    checks++; if (e != 4) begin errors++; $display("FAIL bp_second_latency: got %0d want 4", e); end
    checks++; if (bus.neuron_data_out !== 12'h800) begin errors++; $display("FAIL bp_second_data: got %0d want -2048", $signed(bus.neuron_data_out)); end
    consume();
  endtask

  task automatic test_async_reset();
    bit seen;
    accept(mk(512, 512, 512, 512), mk(512, 256, 0, -512), 0, 2'd1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.neuron_valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.neuron_valid_out); end
    checks++; if (bus.neuron_data_out !== 12'd0) begin errors++; $display("FAIL arst_data: got %0d want 0", $signed(bus.neuron_data_out)); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.neuron_ready_in !== 1'b1) begin errors++; $display("FAIL arst_ready_in: got %b want 1", bus.neuron_ready_in); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.neuron_valid_out) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst_no_output: got valid_out=1 want none"); end
  endtask

  task automatic test_sweep();
    int l1, l4;
    logic [DW-1:0] d1, d4;
    bus1.neuron_data_in = mk(512, 512, 512, 512); bus1.neuron_weights = mk(512, 256, 0, -512);
    bus4.neuron_data_in = mk(512, 512, 512, 512); bus4.neuron_weights = mk(512, 256, 0, -512);
    bus1.neuron_act_mode = 2'd1; bus4.neuron_act_mode = 2'd1;
    bus1.neuron_ready_out = 1'b1; bus4.neuron_ready_out = 1'b1;
    bus1.neuron_valid_in = 1'b1; bus4.neuron_valid_in = 1'b1;
    @(posedge clk); #1;
    bus1.neuron_valid_in = 1'b0; bus4.neuron_valid_in = 1'b0;
    l1 = -1; l4 = -1; d1 = '0; d4 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus1.neuron_valid_out && l1 < 0) begin l1 = i; d1 = bus1.neuron_data_out; end
      if (bus4.neuron_valid_out && l4 < 0) begin l4 = i; d4 = bus4.neuron_data_out; end
    end
    checks++; if (l1 != 6) begin errors++; $display("FAIL sweep_m1_latency: got %0d want 6", l1); end
    checks++; if (l4 != 3) begin errors++; $display("FAIL sweep_m4_latency: got %0d want 3", l4); end
    checks++; if (d1 !== 12'd256) begin errors++; $display("FAIL sweep_m1_data: got %0d want 256", $signed(d1)); end
    checks++; if (d4 !== 12'd256) begin errors++; $display("FAIL sweep_m4_data: got %0d want 256", $signed(d4)); end
  endtask

  task automatic test_random();
    vec_t x, w;
    logic [DW-1:0] b, ey;
    logic [1:0] mode;
    logic es;
    int e;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (n % 2 == 1) begin
          x[i] = DW'(int'($urandom_range(0, 1023)) - 512);
          w[i] = DW'(int'($urandom_range(0, 1023)) - 512);
        end else begin
          x[i] = DW'($urandom_range(0, 4095));
          w[i] = DW'($urandom_range(0, 4095));
        end
      end
      b    = DW'($urandom_range(0, 4095));
      mode = 2'($urandom_range(0, 3));
      ref_model(x, w, b, mode, ey, es);
      accept(x, w, int'($signed(b)), mode);
      wait_valid(e);
      checks++; if (e != 4 || bus.neuron_data_out !== ey || bus.neuron_sat_out !== es)
        begin errors++; $display("FAIL random[%0d]: got lat=%0d d=%0d s=%b want lat=4 d=%0d s=%b", n, e, $signed(bus.neuron_data_out), bus.neuron_sat_out, $signed(ey), es); end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_saturation();
    test_backpressure();
    test_async_reset();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
